// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - button inputs, collision input and game-flow outputs of game_sequencer
interface game_sequencer_if;
  logic       start_btn;
  logic       pause_btn;
  logic       pacman_is_dead;
  logic       pacman_tick;
  logic       ghost_tick;
  logic       respawn;
  logic [1:0] lives;
  logic [2:0] game_state;
  logic       game_over;
  logic       paused;

  modport master (
    input  start_btn, pause_btn, pacman_is_dead,
    output pacman_tick, ghost_tick, respawn, lives, game_state, game_over, paused
  );

  modport slave (
    output start_btn, pause_btn, pacman_is_dead,
    input  pacman_tick, ghost_tick, respawn, lives, game_state, game_over, paused
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Pac-Man round FSM, move strobes, respawn pulse and lives
// Optional pause feature is built only when GAME_PAUSE_EN is defined.
module game_sequencer #(
  parameter int unsigned PAC_DIV      = 4,
  parameter int unsigned GHOST_DIV    = 6,
  parameter int unsigned READY_CYCLES = 16,
  parameter int unsigned DEATH_CYCLES = 32,
  parameter int unsigned START_LIVES  = 3
) (
  input  logic               clk,
  input  logic               rst,
  game_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [23:0] PAC_LAST   = 24'(PAC_DIV - 1);
  localparam logic [23:0] GHOST_LAST = 24'(GHOST_DIV - 1);
  localparam logic [23:0] READY_LAST = 24'(READY_CYCLES - 1);
  localparam logic [23:0] DEATH_LAST = 24'(DEATH_CYCLES - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);

  state_t      state;
  state_t      state_next;
  logic [23:0] phase_cnt;
  logic [23:0] pac_cnt;
  logic [23:0] ghost_cnt;
  logic [1:0]  lives;
  logic        start_prev;
  logic        start_edge;
  logic        paused;
  logic        running;
  logic        pac_hit;
  logic        ghost_hit;

  assign start_edge = bus.start_btn & ~start_prev;
  assign running    = (state == S_PLAY) & ~paused;
  assign pac_hit    = (pac_cnt == PAC_LAST);
  assign ghost_hit  = (ghost_cnt == GHOST_LAST);

`ifdef GAME_PAUSE_EN
  logic pause_prev;
  logic pause_edge;

  assign pause_edge = bus.pause_btn & ~pause_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_prev <= 1'b1;
      paused     <= 1'b0;
    end else begin
      pause_prev <= bus.pause_btn;
      if (state_next != S_PLAY)
        paused <= 1'b0;
      else if ((state == S_PLAY) && pause_edge)
        paused <= ~paused;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
  assign paused       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start_edge) state_next = S_READY;
      S_READY: if (phase_cnt == READY_LAST) state_next = S_PLAY;
      S_PLAY:  if (bus.pacman_is_dead && !paused) state_next = S_DYING;
      // lives has already been decremented on entry to DYING
      S_DYING: if (phase_cnt == DEATH_LAST) state_next = (lives == 2'd0) ? S_OVER : S_READY;
      S_OVER:  if (start_edge) state_next = S_READY;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_prev <= 1'b1;
      lives      <= LIVES_INIT;
      phase_cnt  <= '0;
      pac_cnt    <= '0;
      ghost_cnt  <= '0;
    end else begin
      start_prev <= bus.start_btn;

      if ((state_next != state) || !((state == S_READY) || (state == S_DYING)))
        phase_cnt <= '0;
      else
        phase_cnt <= phase_cnt + 24'd1;

      // dividers hold while paused so play resumes mid-step
      if (state_next != state) begin
        pac_cnt   <= '0;
        ghost_cnt <= '0;
      end else if (running) begin
        pac_cnt   <= pac_hit   ? 24'd0 : pac_cnt + 24'd1;
        ghost_cnt <= ghost_hit ? 24'd0 : ghost_cnt + 24'd1;
      end

      if ((state == S_PLAY) && (state_next == S_DYING) && (lives != 2'd0))
        lives <= lives - 2'd1;
      else if ((state == S_OVER) && (state_next == S_READY))
        lives <= LIVES_INIT;
    end
  end

  always_comb begin
    bus.game_state  = state;
    bus.lives       = lives;
    bus.pacman_tick = running & pac_hit;
    bus.ghost_tick  = running & ghost_hit;
    bus.respawn     = (state == S_READY) && (phase_cnt == 24'd0);
    bus.game_over   = (state == S_OVER);
    bus.paused      = paused;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized bench for game_sequencer against a cycle-count reference model
module tb_game_sequencer;
  localparam int PAC_DIV      = 4;
  localparam int GHOST_DIV    = 6;
  localparam int READY_CYCLES = 8;
  localparam int DEATH_CYCLES = 10;
  localparam int START_LIVES  = 2;
  localparam int N_CYCLES     = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .PAC_DIV      (PAC_DIV),
    .GHOST_DIV    (GHOST_DIV),
    .READY_CYCLES (READY_CYCLES),
    .DEATH_CYCLES (DEATH_CYCLES),
    .START_LIVES  (START_LIVES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // reference: state code, lives, cycles spent in state, unpaused PLAY cycles elapsed
  int m_state, m_lives, m_t, m_run;
  bit m_paused, m_prev_start, m_prev_pause;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit d);
    bit se, pe;
    int ns;
    rst = r;
    bus.start_btn = s;
    bus.pause_btn = p;
    bus.pacman_is_dead = d;
    if (r) begin
      m_state = 0; m_lives = START_LIVES; m_t = 0; m_run = 0;
      m_paused = 0; m_prev_start = 1; m_prev_pause = 1;
      return;
    end
    se = s && !m_prev_start;
    pe = p && !m_prev_pause;
    ns = m_state;
    case (m_state)
      0: if (se) ns = 1;
      1: if (m_t == READY_CYCLES - 1) ns = 2;
      2: if (d && !m_paused) begin ns = 3; m_lives--; end
      3: if (m_t == DEATH_CYCLES - 1) ns = (m_lives == 0) ? 4 : 1;
      4: if (se) begin ns = 1; m_lives = START_LIVES; end
      default: ns = 0;
    endcase
    if (m_state == 2 && !m_paused) m_run++;
`ifdef GAME_PAUSE_EN
    if (m_state == 2 && pe) m_paused = !m_paused;
`endif
    if (ns != 2) m_paused = 0;
    if (ns != m_state) begin m_t = 0; m_run = 0; end
    else m_t++;
    m_state = ns;
    m_prev_start = s;
    m_prev_pause = p;
  endtask

  task automatic check_outputs();
    bit in_play;
    in_play = (m_state == 2) && !m_paused;
    check("game_state",  bus.game_state,  m_state);
    check("lives",       bus.lives,       m_lives);
    check("respawn",     bus.respawn,     (m_state == 1) && (m_t == 0));
    check("game_over",   bus.game_over,   m_state == 4);
    check("paused",      bus.paused,      m_paused);
    check("pacman_tick", bus.pacman_tick, in_play && ((m_run % PAC_DIV) == PAC_DIV - 1));
    check("ghost_tick",  bus.ghost_tick,  in_play && ((m_run % GHOST_DIV) == GHOST_DIV - 1));
  endtask

  initial begin
    bit s, p, d, r;
    bit mid_rst_done, mid_rst_check;
    s = 1; p = 0; d = 0; r = 1;
    mid_rst_done = 0; mid_rst_check = 0;
    @(negedge clk);
    drive(1, 1, 0, 0);
    for (cyc = 1; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == 30) check("start_held_idle", bus.game_state, 0);
      if (mid_rst_check) begin
        check("mid_dying_rst_lives", bus.lives, START_LIVES);
        check("mid_dying_rst_state", bus.game_state, 0);
        mid_rst_check = 0;
      end
      r = 0;
      d = 0;
      if (cyc <= 2) begin
        r = 1; s = 1;
      end else if (cyc <= 30) begin
        s = 1;
      end else if (cyc == 31) begin
        s = 0;
      end else if (cyc == 32) begin
        s = 1;
      end else begin
        if ($urandom_range(0, 7) == 0) s = !s;
        if ($urandom_range(0, 24) == 0) p = !p;
        d = ($urandom_range(0, 29) == 0);
        if (m_state == 3 && m_t == 5 && !mid_rst_done) begin
          r = 1; mid_rst_done = 1; mid_rst_check = 1;
        end else if ($urandom_range(0, 699) == 0) begin
          r = 1;
        end
      end
      drive(r, s, p, d);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
